local_predictor_table: RTL and testbench

Pattern-history table that consumes the 2-bit global-history select (`LocalSrc`) and turns it into a taken/not-taken prediction. Holds one bank of 2-bit saturating counters per global-history pattern, indexed by fetch PC bits. Prediction is read in Fetch. The counter that made the prediction is trained in Execute when the branch resolves, using the same enable/outcome pair that drives the global history register.

---
 rtl/local_predictor_table.sv | 92 +++++++++
 tb/tb_local_predictor_table.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/local_predictor_table.sv
// local_predictor_table
//   Pattern-history table of 2-bit saturating counters, four banks (one per
//   2-bit global-history pattern) of 2^IDX_BITS entries indexed by PC[IDX_BITS+1:2].
//   Combinational read in Fetch, saturating update in Execute, registered
//   mispredict flag computed from the pre-update counter.
//   Optional feature macro: PREDICTOR_BYPASS_EN -- forwards the post-update
//   counter MSB to PredTakenF when Fetch reads the entry being trained.
module local_predictor_table #(
    parameter int IDX_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic [1:0]  LocalSrc,
    output logic        PredTakenF,
    input  logic [31:0] PCE,
    input  logic [1:0]  LocalSrcE,
    input  logic        BranchOpEb0,
    input  logic        PCSrcResE,
    output logic        MispredictE
);

    localparam int IDX_W = IDX_BITS + 2;
    localparam int DEPTH = 1 << IDX_W;

    // Counter storage; lives in flops because the whole table must clear asynchronously.
    logic [1:0]       r_table [DEPTH];
    logic             r_mispredict;

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_up_idx;
    logic [1:0]       w_rd_ctr;
    logic [1:0]       w_up_ctr;
    logic [1:0]       w_up_next;
    logic             w_unused_pc;

    // Bank select is the history pattern, the low PC bits pick the entry.
    assign w_rd_idx = {LocalSrc,  PCF[IDX_BITS+1:2]};
    assign w_up_idx = {LocalSrcE, PCE[IDX_BITS+1:2]};
    assign w_rd_ctr = r_table[w_rd_idx];
    assign w_up_ctr = r_table[w_up_idx];

    // Byte-offset and high PC bits play no part in indexing.
    assign w_unused_pc = ^{PCF[31:IDX_BITS+2], PCF[1:0], PCE[31:IDX_BITS+2], PCE[1:0]};

    // Saturating increment on taken, saturating decrement on not-taken.
    always_comb begin
        w_up_next = w_up_ctr;
        if (PCSrcResE) begin
            if (w_up_ctr != 2'b11) begin
                w_up_next = w_up_ctr + 2'b01;
            end
        end else begin
            if (w_up_ctr != 2'b00) begin
                w_up_next = w_up_ctr - 2'b01;
            end
        end
    end

    // Train exactly one counter per resolved branch; reset restores weakly not-taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 2'b01;
            end
        end else if (BranchOpEb0) begin
            r_table[w_up_idx] <= w_up_next;
        end
    end

    // Flag a branch whose pre-update prediction disagreed with the outcome.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= BranchOpEb0 & (w_up_ctr[1] ^ PCSrcResE);
        end
    end

    assign MispredictE = r_mispredict;

`ifdef PREDICTOR_BYPASS_EN
    logic w_bypass_hit;

    // Forward the counter being written this cycle; suppressed while reset holds the table.
    assign w_bypass_hit = reset & BranchOpEb0 & (w_rd_idx == w_up_idx);
    assign PredTakenF   = w_bypass_hit ? w_up_next[1] : w_rd_ctr[1];
`else
    assign PredTakenF   = w_rd_ctr[1];
`endif

endmodule

// File: tb/tb_local_predictor_table.sv
// Testbench for local_predictor_table: directed scenarios plus randomized
// traffic, checked by a scoreboard against a counter-array reference model.
module tb_local_predictor_table;

    localparam int IDX_BITS = 5;
    localparam int NENT     = 1 << IDX_BITS;
    localparam int NTOT     = 4 * NENT;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic [1:0]  LocalSrc;
    logic        PredTakenF;
    logic [31:0] PCE;
    logic [1:0]  LocalSrcE;
    logic        BranchOpEb0;
    logic        PCSrcResE;
    logic        MispredictE;

    local_predictor_table #(.IDX_BITS(IDX_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .LocalSrc    (LocalSrc),
        .PredTakenF  (PredTakenF),
        .PCE         (PCE),
        .LocalSrcE   (LocalSrcE),
        .BranchOpEb0 (BranchOpEb0),
        .PCSrcResE   (PCSrcResE),
        .MispredictE (MispredictE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   due;
        logic val;
    } mis_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ntx      = 0;
    int   model [NTOT];
    logic q_pred [$];
    mis_t q_mis  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [1:0] ls, input logic [31:0] pc);
        return int'(ls) * NENT + int'(pc[IDX_BITS+1:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NTOT; i++) model[i] = 1;
    endtask

    // Monitor: prediction is compared mid-cycle, mispredict after the edge it is due.
    always @(negedge clk) begin
        logic e;
        if (q_pred.size() > 0) begin
            e = q_pred.pop_front();
            chk("pred", PredTakenF, e);
        end
    end

    always @(posedge clk) begin
        mis_t m;
        #2;
        while (q_mis.size() > 0 && q_mis[0].due <= cyc) begin
            m = q_mis.pop_front();
            chk("mispredict", MispredictE, m.val);
        end
    end

    // One transaction per cycle: drive, predict expected results, update the model.
    task automatic drive(input logic [31:0] pcf, input logic [1:0] ls,
                         input logic [31:0] pce, input logic [1:0] lse,
                         input logic br, input logic tk);
        int   ri, ui, nxt;
        logic ep;
        mis_t m;
        @(posedge clk);
        #1;
        PCF = pcf; LocalSrc = ls; PCE = pce; LocalSrcE = lse;
        BranchOpEb0 = br; PCSrcResE = tk;
        ri  = idx_of(ls, pcf);
        ui  = idx_of(lse, pce);
        nxt = tk ? ((model[ui] == 3) ? 3 : model[ui] + 1)
                 : ((model[ui] == 0) ? 0 : model[ui] - 1);
        ep  = (model[ri] >= 2);
`ifdef PREDICTOR_BYPASS_EN
        if (br && ri == ui) ep = (nxt >= 2);
`endif
        q_pred.push_back(ep);
        m.due = cyc + 1;
        m.val = br && ((model[ui] >= 2) != tk);
        q_mis.push_back(m);
        if (br) model[ui] = nxt;
        ntx++;
        $display("txn %0d rd=%0d up=%0d br=%b tk=%b exp_pred=%b exp_mis=%b",
                 ntx, ri, ui, br, tk, ep, m.val);
    endtask

    task automatic read_at(input logic [31:0] pcf, input logic [1:0] ls);
        drive(pcf, ls, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic sweep_all();
        for (int i = 0; i < NTOT; i++) begin
            read_at(32'((i % NENT) << 2), 2'(i / NENT));
        end
    endtask

    // Main stimulus
    initial begin
        logic [31:0] r, pa, pb;
        reset = 1'b0; PCF = '0; LocalSrc = '0; PCE = '0; LocalSrcE = '0;
        BranchOpEb0 = 1'b0; PCSrcResE = 1'b0;
        model_reset();

        // Under reset, with an update requested on the same index: predictions stay 0.
        #3;
        for (int i = 0; i < NTOT; i++) begin
            PCF = 32'((i % NENT) << 2); LocalSrc = 2'(i / NENT);
            PCE = PCF; LocalSrcE = LocalSrc; BranchOpEb0 = 1'b1; PCSrcResE = 1'b1;
            #1;
            chk("reset_pred", PredTakenF, 1'b0);
            chk("reset_mis", MispredictE, 1'b0);
        end
        BranchOpEb0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        sweep_all();

        // Same-cycle read/update collision on a fresh entry.
        drive(32'h80, 2'b01, 32'h80, 2'b01, 1'b1, 1'b1);
        read_at(32'h80, 2'b01);

        // Saturate up then down at PC 0x40, bank 01.
        for (int k = 0; k < 4; k++) drive(32'h40, 2'b01, 32'h40, 2'b01, 1'b1, 1'b1);
        read_at(32'h40, 2'b01);
        for (int k = 0; k < 4; k++) begin
            drive(32'h1000, 2'b10, 32'h40, 2'b01, 1'b1, 1'b0);
            read_at(32'h40, 2'b01);
        end

        // Bank isolation.
        for (int k = 0; k < 2; k++) drive(32'h100, 2'b10, 32'h40, 2'b11, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) read_at(32'h40, 2'(b));
        read_at(32'h44, 2'b11);

        // Enable gating: outcome toggles but no branch is resolved.
        for (int k = 0; k < 32; k++)
            drive(32'((k % 8) << 2) | 32'h40, 2'(k % 4), 32'h40, 2'b11, 1'b0, 1'((k / 4) % 2));
        for (int b = 0; b < 4; b++) read_at(32'h40, 2'(b));

        // Randomized traffic on a small index set so counters saturate and collide.
        for (int k = 0; k < 400; k++) begin
            r  = $urandom();
            pa = (r & ~32'h7C) | 32'($urandom_range(0, 3) << 2);
            r  = $urandom();
            pb = ($urandom_range(0, 3) == 0) ? pa : ((r & ~32'h7C) | 32'($urandom_range(0, 3) << 2));
            drive(pa, 2'($urandom_range(0, 3)), pb, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Train one entry strongly taken, then reset mid-run.
        for (int k = 0; k < 3; k++) drive(32'h8, 2'b10, 32'h8, 2'b10, 1'b1, 1'b1);
        read_at(32'h8, 2'b10);
        read_at(32'h8, 2'b10);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_pred", PredTakenF, 1'b0);
        chk("midreset_mis", MispredictE, 1'b0);
        model_reset();
        for (int i = 0; i < NTOT; i += 7) begin
            PCF = 32'((i % NENT) << 2); LocalSrc = 2'(i / NENT);
            #1;
            chk("midreset_sweep", PredTakenF, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        sweep_all();

        repeat (3) @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
